// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file widths and arbiter state encoding
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ARB, ARB_DRAIN} arb_state_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// rtl/rf_wr_fifo.sv - synchronous FIFO of {rd, data} register writes
module rf_wr_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push,
  input  logic [REG_ADDR_W-1:0]   i_rd,
  input  logic [XLEN-1:0]         i_data,
  input  logic                    i_pop,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [REG_ADDR_W-1:0]   o_head_rd,
  output logic [XLEN-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full      = (r_count == (PW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_rd   = r_rd[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;
  assign w_push_ok   = i_push && !o_full;
  assign w_pop_ok    = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_rd[r_wptr]   <= i_rd;
        r_data[r_wptr] <= i_data;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop_ok);
    end
  end
endmodule

// File: rtl/rf_write_port_arbiter.sv
// rtl/rf_write_port_arbiter.sv - shares the RF write port between pipeline WB
// and a buffered multi-cycle result stream, with starvation drain and pending-rd mask
module rf_write_port_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pipe_regwrite,
  input  logic [REG_ADDR_W-1:0] i_pipe_rd,
  input  logic [XLEN-1:0]       i_pipe_result,
  output logic                  o_pipe_accept,
  output logic                  o_pipe_stall,
  input  logic                  i_mc_valid,
  input  logic [REG_ADDR_W-1:0] i_mc_rd,
  input  logic [XLEN-1:0]       i_mc_data,
  output logic                  o_mc_ready,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_rd,
  output logic [XLEN-1:0]       o_rf_wd,
  output logic [NUM_REGS-1:0]   o_pending_rd_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t            r_state;
  logic [CW-1:0]         r_starve_cnt;
  logic [NUM_REGS-1:0]   r_mask;

  logic                  w_full;
  logic                  w_empty;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]       w_head_data;
  logic [PW:0]           w_count;
  logic                  w_push;
  logic                  w_pipe_win;
  logic                  w_pop;
  logic                  w_last_pop;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;

  // x0 writes are accepted on the handshake but never enter the buffer.
  assign o_mc_ready = !w_full && !r_mask[i_mc_rd] && (r_state != ARB_DRAIN);
  assign w_push     = i_mc_valid && o_mc_ready && (i_mc_rd != '0);
  assign w_pipe_win = (r_state != ARB_DRAIN) && i_pipe_regwrite;
  assign w_pop      = !w_pipe_win && !w_empty;
  assign w_last_pop = w_pop && (w_count == (PW+1)'(1)) && !w_push;

  assign o_pipe_accept     = w_pipe_win;
  assign o_pipe_stall      = (r_state == ARB_DRAIN);
  assign o_pending_rd_mask = r_mask;

  assign w_set = w_push ? (NUM_REGS'(1) << i_mc_rd)   : '0;
  assign w_clr = w_pop  ? (NUM_REGS'(1) << w_head_rd) : '0;

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_rd        (i_mc_rd),
    .i_data      (i_mc_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rf_we <= 1'b0;
      o_rf_rd <= '0;
      o_rf_wd <= '0;
      r_mask  <= '0;
    end else begin
      if (w_pipe_win) begin
        o_rf_we <= (i_pipe_rd != '0);
        o_rf_rd <= i_pipe_rd;
        o_rf_wd <= i_pipe_result;
      end else if (w_pop) begin
        o_rf_we <= 1'b1;
        o_rf_rd <= w_head_rd;
        o_rf_wd <= w_head_data;
      end else begin
        o_rf_we <= 1'b0;
      end
      r_mask <= (r_mask & ~w_clr) | w_set;
    end
  end

  // In ARB the buffer is never empty, so a cycle without a pop is a lost cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ARB_IDLE;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_starve_cnt <= '0;
          if (w_push) r_state <= ARB_ARB;
        end
        ARB_ARB: begin
          if (w_pop) begin
            r_starve_cnt <= '0;
            if (w_last_pop) r_state <= ARB_IDLE;
          end else if (r_starve_cnt == CW'(STARVE_LIMIT - 1)) begin
            r_starve_cnt <= CW'(STARVE_LIMIT);
            r_state      <= ARB_DRAIN;
          end else begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        ARB_DRAIN: begin
          if (w_last_pop) begin
            r_state      <= ARB_IDLE;
            r_starve_cnt <= '0;
          end
        end
        default: begin
          r_state      <= ARB_IDLE;
          r_starve_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// tb/tb_rf_write_port_arbiter.sv - bench for the RF write-port arbiter
module tb_rf_write_port_arbiter;
  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_regwrite = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_result = '0;
  logic        pipe_accept, pipe_stall;
  logic        mc_valid = 1'b0;
  logic [4:0]  mc_rd = '0;
  logic [31:0] mc_data = '0;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] pending_rd_mask;

  int errors = 0;
  int checks = 0;

  rf_write_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_pipe_regwrite   (pipe_regwrite),
    .i_pipe_rd         (pipe_rd),
    .i_pipe_result     (pipe_result),
    .o_pipe_accept     (pipe_accept),
    .o_pipe_stall      (pipe_stall),
    .i_mc_valid        (mc_valid),
    .i_mc_rd           (mc_rd),
    .i_mc_data         (mc_data),
    .o_mc_ready        (mc_ready),
    .o_rf_we           (rf_we),
    .o_rf_rd           (rf_rd),
    .o_rf_wd           (rf_wd),
    .o_pending_rd_mask (pending_rd_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic pw; logic [4:0] prd; logic [31:0] pres;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic acc; logic rdy; logic stl;
    logic we; logic [4:0] rd; logic [31:0] wd; logic [31:0] mask;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pres,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_regwrite = pw; pipe_rd = prd; pipe_result = pres;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: an ordered list of queued writes plus a drain flag and lost count.
  logic [4:0]  q_rd[$];
  logic [31:0] q_d[$];
  logic        m_drain;
  int          m_lost;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q_rd[i]) m[q_rd[i]] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    q_rd.delete(); q_d.delete();
    m_drain = 1'b0; m_lost = 0;
    m_we = 1'b0; m_rd = '0; m_wd = '0;
  endtask

  initial begin
    logic [31:0] msk;
    logic        e_rdy, e_acc, rst, had_head;

    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,      1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'd0};
    tbl[1] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,      1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'd0};
    tbl[2] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd7, 32'h1234,   1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
    tbl[3] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234,     32'd0};
    tbl[4] = '{1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h99,     1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55,       32'd0};
    tbl[5] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,      1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55,       32'd0};

    do_reset();
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_rd", 32'(rf_rd), 32'd0);
    chk("reset_wd", rf_wd, 32'd0);
    chk("reset_stall", 32'(pipe_stall), 32'd0);
    chk("reset_mask", pending_rd_mask, 32'd0);
    chk("reset_ready", 32'(mc_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].pw, tbl[i].prd, tbl[i].pres, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      #1;
      chk($sformatf("vec%0d_accept", i), 32'(pipe_accept), 32'(tbl[i].acc));
      chk($sformatf("vec%0d_ready", i), 32'(mc_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_stall", i), 32'(pipe_stall), 32'(tbl[i].stl));
      tick();
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_rd", i), 32'(rf_rd), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_wd", i), rf_wd, tbl[i].wd);
      chk($sformatf("vec%0d_mask", i), pending_rd_mask, tbl[i].mask);
    end

    // Starvation: three lost cycles force a one-entry drain, then the pipe resumes.
    do_reset();
    drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd3, 32'h33);
    #1; chk("starve_push_ready", 32'(mc_ready), 32'd1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 32'd0);
      #1;
      chk($sformatf("starve_c%0d_stall", c), 32'(pipe_stall), 32'd0);
      chk($sformatf("starve_c%0d_accept", c), 32'(pipe_accept), 32'd1);
      chk($sformatf("starve_c%0d_mask", c), pending_rd_mask, 32'h8);
      tick();
    end
    #1;
    chk("starve_drain_stall", 32'(pipe_stall), 32'd1);
    chk("starve_drain_accept", 32'(pipe_accept), 32'd0);
    tick();
    chk("starve_drain_we", 32'(rf_we), 32'd1);
    chk("starve_drain_rd", 32'(rf_rd), 32'd3);
    chk("starve_drain_wd", rf_wd, 32'h33);
    chk("starve_drain_mask", pending_rd_mask, 32'd0);
    #1;
    chk("starve_resume_stall", 32'(pipe_stall), 32'd0);
    chk("starve_resume_accept", 32'(pipe_accept), 32'd1);
    tick();
    chk("starve_resume_rd", 32'(rf_rd), 32'd9);

    // Duplicate rd and full buffer both refuse the secondary requester.
    do_reset();
    drive(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd1, 32'h101); tick();
    drive(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd2, 32'h102); tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h202);
    #1; chk("dup_ready", 32'(mc_ready), 32'd0);
    tick(); chk("dup_pop_rd", 32'(rf_rd), 32'd1);
    drive(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd3, 32'h103); tick();
    drive(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd4, 32'h104); tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105); tick();
    chk("full_pop_rd", 32'(rf_rd), 32'd2);
    drive(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd6, 32'h106); tick();
    drive(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd7, 32'h107);
    #1;
    chk("full_ready", 32'(mc_ready), 32'd0);
    chk("full_stall", 32'(pipe_stall), 32'd0);
    chk("full_mask", pending_rd_mask, 32'h78);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (4) tick();
    chk("full_last_rd", 32'(rf_rd), 32'd6);
    chk("full_last_wd", rf_wd, 32'h106);
    chk("full_empty_mask", pending_rd_mask, 32'd0);

    // Reset during DRAIN discards all queued writes.
    do_reset();
    drive(1'b1, 5'd20, 32'hA, 1'b1, 5'd10, 32'h10A); tick();
    drive(1'b1, 5'd20, 32'hA, 1'b1, 5'd11, 32'h10B); tick();
    drive(1'b1, 5'd20, 32'hA, 1'b1, 5'd12, 32'h10C); tick();
    drive(1'b1, 5'd20, 32'hA, 1'b0, 5'd0, 32'd0); tick();
    drive(1'b1, 5'd20, 32'hA, 1'b0, 5'd13, 32'd0);
    #1; chk("rst_pre_stall", 32'(pipe_stall), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_mask", pending_rd_mask, 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_ready", 32'(mc_ready), 32'd1);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("rst_after%0d_we", c), 32'(rf_we), 32'd0);
    end

    // Randomized traffic against the queue model.
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      if (!m_drain)
        drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
      else begin
        mc_valid = 1'($urandom_range(0, 1));
        mc_rd    = 5'($urandom_range(0, 7));
        mc_data  = $urandom();
      end
      rst = ($urandom_range(0, 299) == 0);
      reset = rst;
      #1;
      msk   = model_mask();
      e_rdy = (q_rd.size() < DEPTH) && !msk[mc_rd] && !m_drain;
      e_acc = !m_drain && pipe_regwrite;
      chk("rand_accept", 32'(pipe_accept), 32'(e_acc));
      chk("rand_ready", 32'(mc_ready), 32'(e_rdy));
      chk("rand_stall", 32'(pipe_stall), 32'(m_drain));
      chk("rand_mask", pending_rd_mask, msk);
      if (rst) begin
        model_clear();
      end else begin
        had_head = (q_rd.size() > 0);
        if (e_acc) begin
          m_we = (pipe_rd != 0); m_rd = pipe_rd; m_wd = pipe_result;
          if (had_head) m_lost++;
        end else if (had_head) begin
          m_we = 1'b1; m_rd = q_rd.pop_front(); m_wd = q_d.pop_front();
          m_lost = 0;
        end else begin
          m_we = 1'b0;
        end
        if (mc_valid && e_rdy && mc_rd != 0) begin
          q_rd.push_back(mc_rd); q_d.push_back(mc_data);
        end
        if (m_lost >= STARVE) m_drain = 1'b1;
        if (q_rd.size() == 0) begin m_drain = 1'b0; m_lost = 0; end
      end
      tick();
      reset = 1'b0;
      chk("rand_we", 32'(rf_we), 32'(m_we));
      chk("rand_rd", 32'(rf_rd), 32'(m_rd));
      chk("rand_wd", rf_wd, m_wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
